// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_ctrl
// Purpose  : Fetch/decode hazard controller for the PC and IF/ID register:
//            boot flush, branch redirect, load-use stall, instruction-memory
//            wait, halt, plus saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic        pcwrite,
    output logic        ifidwrite,
    output logic        flush,
    output logic        pcsrc,
    output logic [31:0] pc_imm,
    output logic        id_bubble,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [1:0]  c_BOOT    = 2'd0;
    localparam logic [1:0]  c_RUN     = 2'd1;
    localparam logic [1:0]  c_HALT    = 2'd2;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_load_use;
    logic        w_in_run;
    logic        w_stall_evt;
    logic        w_flush_evt;

    assign w_load_use = idex_memread && (idex_rd != 5'd0) &&
                        ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

    assign w_in_run    = (r_state == c_RUN);
    // A branch outranks the stall sources, so a redirect cycle never counts as a stall.
    assign w_stall_evt = w_in_run && !branch_taken && (w_load_use || !imem_ready);
    assign w_flush_evt = w_in_run && branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_BOOT: w_next_state = c_RUN;
            c_RUN: begin
                if (!branch_taken && !w_load_use && imem_ready && halt_req) begin
                    w_next_state = c_HALT;
                end
            end
            c_HALT:  w_next_state = c_HALT;
            default: w_next_state = c_BOOT;
        endcase
    end

    // Outputs default to the BOOT pattern; reset forces it regardless of state.
    always_comb begin
        pcwrite   = 1'b0;
        ifidwrite = 1'b0;
        flush     = 1'b1;
        pcsrc     = 1'b0;
        pc_imm    = 32'd0;
        id_bubble = 1'b1;
        halted    = 1'b0;
        if (!rst) begin
            case (r_state)
                c_RUN: begin
                    if (branch_taken) begin
                        pcwrite   = 1'b1;
                        ifidwrite = 1'b1;
                        flush     = 1'b1;
                        pcsrc     = 1'b1;
                        pc_imm    = branch_target;
                        id_bubble = 1'b1;
                    end else if (w_load_use) begin
                        flush     = 1'b0;
                        id_bubble = 1'b1;
                    end else if (!imem_ready) begin
                        flush     = 1'b0;
                        id_bubble = 1'b0;
                    end else if (halt_req) begin
                        flush     = 1'b1;
                        id_bubble = 1'b0;
                    end else begin
                        pcwrite   = 1'b1;
                        ifidwrite = 1'b1;
                        flush     = 1'b0;
                        id_bubble = 1'b0;
                    end
                end
                c_HALT: begin
                    flush     = 1'b1;
                    id_bubble = 1'b0;
                    halted    = 1'b1;
                end
                default: begin
                    flush     = 1'b1;
                    id_bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_flush_evt && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_ctrl
// Purpose  : Directed scenarios plus randomized traffic for fetch_ctrl,
//            checked against a cycle-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_ready;
    logic        idex_memread;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt_req;
    logic        pcwrite;
    logic        ifidwrite;
    logic        flush;
    logic        pcsrc;
    logic [31:0] pc_imm;
    logic        id_bubble;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    fetch_ctrl u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_ready    (imem_ready),
        .idex_memread  (idex_memread),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .pcwrite       (pcwrite),
        .ifidwrite     (ifidwrite),
        .flush         (flush),
        .pcsrc         (pcsrc),
        .pc_imm        (pc_imm),
        .id_bubble     (id_bubble),
        .halted        (halted),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    int m_mode  = M_BOOT;
    int m_stall = 0;
    int m_flush = 0;

    typedef struct packed {
        logic        pcwrite;
        logic        ifidwrite;
        logic        flush;
        logic        pcsrc;
        logic        id_bubble;
        logic        halted;
        logic [31:0] pc_imm;
        logic        chk_ifid;
        logic        chk_flush;
    } exp_t;

    function automatic bit model_load_use();
        return idex_memread && (idex_rd != 0) &&
               ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    endfunction

    // Expected combinational outputs from the current model mode and inputs.
    function automatic exp_t model_out();
        exp_t e;
        e = '{pcwrite: 1'b0, ifidwrite: 1'b0, flush: 1'b1, pcsrc: 1'b0,
              id_bubble: 1'b1, halted: 1'b0, pc_imm: 32'd0,
              chk_ifid: 1'b1, chk_flush: 1'b1};
        if (!rst && m_mode == M_HALT) begin
            e.id_bubble = 1'b0;
            e.halted    = 1'b1;
        end else if (!rst && m_mode == M_RUN) begin
            if (branch_taken) begin
                e.pcwrite   = 1'b1;
                e.pcsrc     = 1'b1;
                e.pc_imm    = branch_target;
                e.chk_ifid  = 1'b0;
            end else if (model_load_use()) begin
                e.chk_flush = 1'b0;
            end else if (!imem_ready) begin
                e.id_bubble = 1'b0;
                e.chk_flush = 1'b0;
            end else if (halt_req) begin
                e.id_bubble = 1'b0;
            end else begin
                e.pcwrite   = 1'b1;
                e.ifidwrite = 1'b1;
                e.flush     = 1'b0;
                e.id_bubble = 1'b0;
            end
        end
        return e;
    endfunction

    function automatic void model_advance();
        if (rst) begin
            m_mode  = M_BOOT;
            m_stall = 0;
            m_flush = 0;
        end else if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (branch_taken) begin
                if (m_flush < 65535) m_flush++;
            end else if (model_load_use() || !imem_ready) begin
                if (m_stall < 65535) m_stall++;
            end else if (halt_req) begin
                m_mode = M_HALT;
            end
        end
    endfunction

    task automatic run_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst           = 1'b0;
        imem_ready    = 1'b1;
        idex_memread  = 1'b0;
        idex_rd       = 5'd0;
        ifid_rs1      = 5'd1;
        ifid_rs2      = 5'd2;
        branch_taken  = 1'b0;
        branch_target = 32'd0;
        halt_req      = 1'b0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++;
            if ({pcwrite, ifidwrite, flush, pcsrc, id_bubble, halted} !== 6'b001010) begin
                $display("FAIL reset_outputs: got %b required 001010",
                         {pcwrite, ifidwrite, flush, pcsrc, id_bubble, halted});
            end else n_pass++;
            run_cycle();
        end
        rst = 1'b0;
        #1;
        n_total++;
        if ({pcwrite, flush} !== 2'b01) begin
            $display("FAIL boot_cycle: pcwrite,flush got %b required 01", {pcwrite, flush});
        end else n_pass++;
        run_cycle();
        n_total++;
        if ({pcwrite, ifidwrite, flush} !== 3'b110) begin
            $display("FAIL run_entry: pcwrite,ifidwrite,flush got %b required 110",
                     {pcwrite, ifidwrite, flush});
        end else n_pass++;
        n_total++;
        if ({stall_cnt, flush_cnt} !== 32'd0) begin
            $display("FAIL reset_counters: stall=%0d flush=%0d required 0/0", stall_cnt, flush_cnt);
        end else n_pass++;
    endtask

    task automatic test_load_use();
        idex_memread = 1'b1;
        idex_rd      = 5'd5;
        ifid_rs1     = 5'd7;
        ifid_rs2     = 5'd5;
        #1;
        n_total++;
        if ({pcwrite, ifidwrite, id_bubble, pcsrc} !== 4'b0010) begin
            $display("FAIL load_use_stall: pcwrite,ifidwrite,id_bubble,pcsrc got %b required 0010",
                     {pcwrite, ifidwrite, id_bubble, pcsrc});
        end else n_pass++;
        run_cycle();
        set_idle();
        #1;
        n_total++;
        if (stall_cnt !== 16'd1) begin
            $display("FAIL load_use_count: stall_cnt got %0d required 1", stall_cnt);
        end else n_pass++;
        n_total++;
        if ({pcwrite, ifidwrite, id_bubble} !== 3'b110) begin
            $display("FAIL load_use_resume: got %b required 110", {pcwrite, ifidwrite, id_bubble});
        end else n_pass++;
        run_cycle();
    endtask

    task automatic test_x0_no_stall();
        idex_memread = 1'b1;
        idex_rd      = 5'd0;
        ifid_rs1     = 5'd0;
        ifid_rs2     = 5'd0;
        #1;
        n_total++;
        if ({pcwrite, ifidwrite, id_bubble} !== 3'b110) begin
            $display("FAIL x0_no_stall: got %b required 110", {pcwrite, ifidwrite, id_bubble});
        end else n_pass++;
        run_cycle();
        set_idle();
        #1;
        n_total++;
        if (stall_cnt !== 16'd1) begin
            $display("FAIL x0_count: stall_cnt got %0d required 1", stall_cnt);
        end else n_pass++;
    endtask

    task automatic test_branch_priority();
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        idex_memread  = 1'b1;
        idex_rd       = 5'd5;
        ifid_rs2      = 5'd5;
        halt_req      = 1'b1;
        #1;
        n_total++;
        if ({pcsrc, flush, pcwrite, id_bubble} !== 4'b1111) begin
            $display("FAIL branch_ctrl: pcsrc,flush,pcwrite,id_bubble got %b required 1111",
                     {pcsrc, flush, pcwrite, id_bubble});
        end else n_pass++;
        n_total++;
        if (pc_imm !== 32'h40) begin
            $display("FAIL branch_target: pc_imm got %h required 00000040", pc_imm);
        end else n_pass++;
        run_cycle();
        set_idle();
        #1;
        n_total++;
        if (flush_cnt !== 16'd1) begin
            $display("FAIL branch_count: flush_cnt got %0d required 1", flush_cnt);
        end else n_pass++;
        n_total++;
        if ({halted, pcwrite, pcsrc, pc_imm} !== {1'b0, 1'b1, 1'b0, 32'd0}) begin
            $display("FAIL branch_stays_run: halted=%b pcwrite=%b pcsrc=%b pc_imm=%h required 0 1 0 0",
                     halted, pcwrite, pcsrc, pc_imm);
        end else n_pass++;
        run_cycle();
    endtask

    task automatic test_imem_stall();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if ({pcwrite, ifidwrite, id_bubble, pcsrc} !== 4'b0000) begin
                $display("FAIL imem_wait[%0d]: got %b required 0000", i,
                         {pcwrite, ifidwrite, id_bubble, pcsrc});
            end else n_pass++;
            run_cycle();
        end
        set_idle();
        #1;
        // one stall from the load-use scenario plus three here
        n_total++;
        if (stall_cnt !== 16'd4) begin
            $display("FAIL imem_count: stall_cnt got %0d required 4", stall_cnt);
        end else n_pass++;
        run_cycle();
    endtask

    task automatic test_halt();
        halt_req = 1'b1;
        #1;
        n_total++;
        if ({pcwrite, ifidwrite, flush, id_bubble, halted} !== 5'b00100) begin
            $display("FAIL halt_req: got %b required 00100",
                     {pcwrite, ifidwrite, flush, id_bubble, halted});
        end else n_pass++;
        run_cycle();
        set_idle();
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        #1;
        n_total++;
        if ({halted, pcwrite, ifidwrite, flush, pcsrc, id_bubble} !== 6'b100100 || pc_imm !== 32'd0) begin
            $display("FAIL halt_state: got %b pc_imm=%h required 100100 pc_imm=0",
                     {halted, pcwrite, ifidwrite, flush, pcsrc, id_bubble}, pc_imm);
        end else n_pass++;
        run_cycle();
        #1;
        n_total++;
        if (halted !== 1'b1 || flush_cnt !== 16'd1) begin
            $display("FAIL halt_sticky: halted=%b flush_cnt=%0d required 1 and 1", halted, flush_cnt);
        end else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({halted, flush, id_bubble, pcwrite} !== 4'b0110) begin
            $display("FAIL halt_rst: got %b required 0110", {halted, flush, id_bubble, pcwrite});
        end else n_pass++;
        run_cycle();
        set_idle();
        #1;
        n_total++;
        if ({halted, flush, pcwrite} !== 3'b010 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            $display("FAIL halt_reboot: got %b stall=%0d flush=%0d required 010 0 0",
                     {halted, flush, pcwrite}, stall_cnt, flush_cnt);
        end else n_pass++;
        run_cycle();
        n_total++;
        if ({pcwrite, ifidwrite} !== 2'b11) begin
            $display("FAIL halt_rerun: got %b required 11", {pcwrite, ifidwrite});
        end else n_pass++;
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 99) < 3);
            imem_ready    = ($urandom_range(0, 99) < 80);
            idex_memread  = ($urandom_range(0, 99) < 35);
            idex_rd       = 5'($urandom_range(0, 3));
            ifid_rs1      = 5'($urandom_range(0, 3));
            ifid_rs2      = 5'($urandom_range(0, 3));
            branch_taken  = ($urandom_range(0, 99) < 15);
            branch_target = $urandom;
            halt_req      = ($urandom_range(0, 99) < 4);
            #1;
            e = model_out();
            n_total++;
            if ({pcwrite, pcsrc, id_bubble, halted} !== {e.pcwrite, e.pcsrc, e.id_bubble, e.halted}
                || pc_imm !== e.pc_imm) begin
                $display("FAIL rand_ctrl[%0d]: pw,src,bub,hlt=%b pc_imm=%h required %b %h", i,
                         {pcwrite, pcsrc, id_bubble, halted}, pc_imm,
                         {e.pcwrite, e.pcsrc, e.id_bubble, e.halted}, e.pc_imm);
            end else n_pass++;
            if (e.chk_ifid) begin
                n_total++;
                if (ifidwrite !== e.ifidwrite) begin
                    $display("FAIL rand_ifidwrite[%0d]: got %b required %b", i, ifidwrite, e.ifidwrite);
                end else n_pass++;
            end
            if (e.chk_flush) begin
                n_total++;
                if (flush !== e.flush) begin
                    $display("FAIL rand_flush[%0d]: got %b required %b", i, flush, e.flush);
                end else n_pass++;
            end
            run_cycle();
            n_total++;
            if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush)) begin
                $display("FAIL rand_counters[%0d]: stall=%0d flush=%0d required %0d %0d", i,
                         stall_cnt, flush_cnt, m_stall, m_flush);
            end else n_pass++;
        end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_x0_no_stall();
        test_branch_priority();
        test_imem_stall();
        test_halt();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
